frame_tx: RTL and testbench

//  Raster frame transmitter: the read-out side of the frame capture path. On start, reads one
//  H_PIXELS x V_LINES frame from a synchronous frame-buffer RAM (1-cycle read latency) in raster

---
 rtl/frame_tx_if.sv | 41 ++++
 rtl/frame_tx.sv | 193 +++++++++++++++++++
 tb/tb_frame_tx.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_tx_if.sv
// frame_tx_if: groups the frame transmitter's control, frame-buffer read and pixel
// stream signals. The master modport is the transmitter side; the slave modport is
// the environment (frame-buffer RAM, pixel sink and controller).
// When FRAME_TX_TPG_EN is defined, the interface also carries tpg_sel.
interface frame_tx_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17
);
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;
  logic              busy;
  logic              done;
`ifdef FRAME_TX_TPG_EN
  logic              tpg_sel;

  modport master (
    input  start, rd_data, pix_ready, tpg_sel,
    output rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol, busy, done
  );
  modport slave (
    output start, rd_data, pix_ready, tpg_sel,
    input  rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol, busy, done
  );
`else
  modport master (
    input  start, rd_data, pix_ready,
    output rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol, busy, done
  );
  modport slave (
    output start, rd_data, pix_ready,
    input  rd_en, rd_addr, pix_data, pix_valid, pix_sof, pix_eol, busy, done
  );
`endif
endinterface

// File: rtl/frame_tx.sv
// frame_tx: reads one H_PIXELS x V_LINES frame from a 1-cycle-latency frame buffer in
// raster order and streams it as valid/ready pixels with sof/eol tags.
// Pipeline: read issue (rd_en) -> data on rd_data -> output register, with a 2-entry
// skid FIFO behind the output register to absorb in-flight reads when the sink stalls.
// Optional feature: define FRAME_TX_TPG_EN to add tpg_sel, which replaces RAM data by
// the (col + row) test pattern with identical timing and tags.
module frame_tx #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 17
) (
  input  logic       clk,
  input  logic       rst,
  frame_tx_if.master bus
);
  localparam int NPIX  = H_PIXELS * V_LINES;
  localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_PIXELS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(V_LINES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic             last;
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] data;
  } word_t;

  state_t state_reg, state_next;

  // read-side counters
  logic [ADDR_W-1:0] addr_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [ADDR_W-1:0] rd_addr_reg;

  // stage 1: read strobe cycle; stage 2: read data present on rd_data
  logic       s1_valid_reg, s2_valid_reg;
  logic [2:0] s1_tag_reg, s2_tag_reg;  // {last, sof, eol}

  word_t      fifo_reg [0:1];
  logic [1:0] fifo_count_reg;
  word_t      out_reg;
  logic       out_valid_reg;
  logic       done_reg;

  // combinational control
  logic       pop, out_free, fifo_pop, fifo_push, bypass, issue, last_xfer, done_next;
  logic [1:0] fifo_count_next;
  logic [1:0] wr_slot;
  word_t      s2_word;

`ifdef FRAME_TX_TPG_EN
  logic             tpg_reg;
  logic [PIX_W-1:0] s1_pix_reg, s2_pix_reg;

  // pattern pixels ride the same pipeline as RAM reads so timing is identical
  always_ff @(posedge clk) begin
    if (!rst) begin
      tpg_reg    <= 1'b0;
      s1_pix_reg <= '0;
      s2_pix_reg <= '0;
    end else begin
      if (state_reg == IDLE && bus.start)
        tpg_reg <= bus.tpg_sel;
      if (issue)
        s1_pix_reg <= PIX_W'(col_reg) + PIX_W'(row_reg);
      s2_pix_reg <= s1_pix_reg;
    end
  end

  assign bus.rd_en = s1_valid_reg & ~tpg_reg;
  assign s2_word   = {s2_tag_reg, tpg_reg ? s2_pix_reg : bus.rd_data};
`else
  assign bus.rd_en = s1_valid_reg;
  assign s2_word   = {s2_tag_reg, bus.rd_data};
`endif

  assign bus.rd_addr   = rd_addr_reg;
  assign bus.pix_valid = out_valid_reg;
  assign bus.pix_data  = out_reg.data;
  assign bus.pix_sof   = out_reg.sof;
  assign bus.pix_eol   = out_reg.eol;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = done_reg;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // next state, FIFO steering and read-issue decision
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    pop        = out_valid_reg & bus.pix_ready;
    out_free   = ~out_valid_reg | pop;
    fifo_pop   = out_free & (fifo_count_reg != 2'd0);
    bypass     = out_free & (fifo_count_reg == 2'd0) & s2_valid_reg;
    fifo_push  = s2_valid_reg & ~bypass;
    fifo_count_next = fifo_count_reg + 2'(fifo_push) - 2'(fifo_pop);
    wr_slot    = fifo_pop ? (fifo_count_reg - 2'd1) : fifo_count_reg;
    // FIFO occupancy plus reads still in flight after this edge stays within 2 words,
    // so every outstanding read always has a FIFO slot behind the output register.
    issue      = (state_reg == RUN) && ((fifo_count_next + 2'(s1_valid_reg)) < 2'd2);
    last_xfer  = pop & out_reg.last;
    unique case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (issue && addr_reg == LAST_ADDR) state_next = DRAIN;
      DRAIN:   if (last_xfer) begin
                 state_next = IDLE;
                 done_next  = 1'b1;
               end
      default: state_next = IDLE;
    endcase
  end

  // read-side address/col/row counters and the read pipeline
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_reg     <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      rd_addr_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s1_tag_reg   <= '0;
      s2_tag_reg   <= '0;
    end else begin
      s1_valid_reg <= issue;
      s2_valid_reg <= s1_valid_reg;
      s2_tag_reg   <= s1_tag_reg;
      if (state_reg == IDLE && bus.start) begin
        addr_reg <= '0;
        col_reg  <= '0;
        row_reg  <= '0;
      end else if (issue) begin
        rd_addr_reg <= addr_reg;
        s1_tag_reg  <= {addr_reg == LAST_ADDR,
                        (col_reg == '0) && (row_reg == '0),
                        col_reg == LAST_COL};
        addr_reg    <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
        if (col_reg == LAST_COL) begin
          col_reg <= '0;
          row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  // 2-entry skid FIFO, entry 0 is the head
  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_count_reg <= 2'd0;
    end else begin
      fifo_count_reg <= fifo_count_next;
      if (fifo_pop)
        fifo_reg[0] <= fifo_reg[1];
      if (fifo_push)
        fifo_reg[wr_slot[0]] <= s2_word;
    end
  end

  // output register: refilled from the FIFO head, or straight from the read data when
  // the FIFO is empty; held unchanged while valid and not accepted
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= done_next;
      if (fifo_pop) begin
        out_reg       <= fifo_reg[0];
        out_valid_reg <= 1'b1;
      end else if (bypass) begin
        out_reg       <= s2_word;
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_reg       <= '0;
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: table-driven frame runs plus hand-written start/reset sequences.
// Expected pixels are queued when a frame is started and popped as the sink accepts them.
module tb_frame_tx;
  localparam int H  = 20;
  localparam int V  = 15;
  localparam int PW = 8;
  localparam int AW = 9;
  localparam int N  = H * V;
`ifdef FRAME_TX_TPG_EN
  localparam int NV = 5;
`else
  localparam int NV = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frame_tx_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();
  frame_tx #(.H_PIXELS(H), .V_LINES(V), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // frame-buffer RAM model, 1-cycle read latency
  logic [PW-1:0] mem [N];
  always @(posedge clk)
    if (bus.rd_en)
      bus.rd_data <= (int'(bus.rd_addr) < N) ? mem[int'(bus.rd_addr)] : '0;

  typedef struct packed {
    logic [PW-1:0] d;
    logic          sof;
    logic          eol;
  } pix_t;
  pix_t exp_q[$];
  pix_t mon_e;

  task automatic push_frame(input bit tpg);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) begin
        pix_t p;
        p.d   = tpg ? PW'(r + c) : mem[r * H + c];
        p.sof = (r == 0) && (c == 0);
        p.eol = (c == H - 1);
        exp_q.push_back(p);
      end
  endtask

  // monitor state
  int edge_cnt = 0;
  int xfer_cnt, eol_cnt, sof_cnt, done_cnt, done_edge, first_valid_edge, issued;
  int first_rd_addr;
  bit prev_hold = 1'b0;
  logic [PW+1:0] prev_word;

  // sink ready driver
  bit rnd_ready = 1'b0;
  int stall_at = -1;
  int stall_len = 0;
  int stall_left = 0;
  bit in_stall = 1'b0;
  int stall_reads = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      stall_left--;
      bus.pix_ready = 1'b0;
    end else if (stall_at >= 0 && xfer_cnt >= stall_at) begin
      stall_at      = -1;
      stall_left    = stall_len - 1;
      in_stall      = 1'b1;
      bus.pix_ready = 1'b0;
    end else begin
      in_stall      = 1'b0;
      bus.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(bus.pix_valid), 32'd1);
        check("hold_word", 32'({bus.pix_data, bus.pix_sof, bus.pix_eol}), 32'(prev_word));
      end
      if (bus.rd_en) begin
        if (issued == 0) first_rd_addr = int'(bus.rd_addr);
        issued++;
        if (in_stall) stall_reads++;
        check("outstanding_le2", 32'((issued - xfer_cnt - int'(bus.pix_valid)) <= 2), 32'd1);
      end
      if (bus.pix_valid && first_valid_edge < 0) first_valid_edge = edge_cnt;
      if (bus.pix_valid && bus.pix_ready) begin
        check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("pixel", 32'({bus.pix_data, bus.pix_sof, bus.pix_eol}), 32'(mon_e));
        end
        xfer_cnt++;
        if (bus.pix_eol) eol_cnt++;
        if (bus.pix_sof) sof_cnt++;
      end
      if (bus.done) begin
        done_cnt++;
        done_edge = edge_cnt;
        check("busy_in_done", 32'(bus.busy), 32'd0);
      end
      prev_hold = bus.pix_valid && !bus.pix_ready;
      prev_word = {bus.pix_data, bus.pix_sof, bus.pix_eol};
    end
  end

  task automatic reset_stats();
    xfer_cnt = 0; eol_cnt = 0; sof_cnt = 0; done_cnt = 0; done_edge = -1;
    first_valid_edge = -1; issued = 0; first_rd_addr = -1; stall_reads = 0;
  endtask

  task automatic start_frame(input bit tpg, output int e0);
    push_frame(tpg);
    @(posedge clk); #2;
    bus.start = 1'b1;
`ifdef FRAME_TX_TPG_EN
    bus.tpg_sel = tpg;
`endif
    e0 = edge_cnt + 1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int c0;
    c0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt != c0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // raise start so that it is sampled at the given absolute edge
  task automatic pulse_start_at(input int edge_abs);
    while (edge_cnt < edge_abs - 1) begin
      @(posedge clk); #2;
    end
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  typedef struct {
    string name;
    bit    rnd;
    int    sat;
    int    slen;
    int    exp_done;
    bit    tpg;
  } vec_t;
  vec_t vecs[NV];

  initial begin
    int e0, e1;
    bit ok;

    vecs[0] = '{"full_ready",   1'b0, -1,        0,  N + 3,      1'b0};
    vecs[1] = '{"random_ready", 1'b1, -1,        0,  -1,         1'b0};
    vecs[2] = '{"stall_row5",   1'b0, 5 * H + 7, 20, N + 3 + 20, 1'b0};
    vecs[3] = '{"random_stall", 1'b1, 2 * H + 3, 20, -1,         1'b0};
`ifdef FRAME_TX_TPG_EN
    vecs[4] = '{"tpg_pattern",  1'b0, -1,        0,  N + 3,      1'b1};
    bus.tpg_sel = 1'b0;
`endif

    bus.start = 1'b0;
    bus.pix_ready = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = PW'($urandom);
    reset_stats();

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check("rst_pix_data", 32'(bus.pix_data), 32'd0);
    check("rst_sof_eol", 32'({bus.pix_sof, bus.pix_eol}), 32'd0);
    check("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // table-driven frames
    for (int v = 0; v < NV; v++) begin
      reset_stats();
      rnd_ready = vecs[v].rnd;
      stall_len = vecs[v].slen;
      stall_at  = vecs[v].sat;
      start_frame(vecs[v].tpg, e0);
      wait_done(20 * N, ok);
      check($sformatf("%s_done_seen", vecs[v].name), 32'(ok), 32'd1);
      if (vecs[v].exp_done >= 0)
        check($sformatf("%s_done_cycle", vecs[v].name), 32'(done_edge - e0), 32'(vecs[v].exp_done));
      check($sformatf("%s_first_valid", vecs[v].name), 32'(first_valid_edge - e0), 32'd3);
      check($sformatf("%s_left_in_queue", vecs[v].name), 32'(exp_q.size()), 32'd0);
      check($sformatf("%s_xfers", vecs[v].name), 32'(xfer_cnt), 32'(N));
      check($sformatf("%s_eol_count", vecs[v].name), 32'(eol_cnt), 32'(V));
      check($sformatf("%s_sof_count", vecs[v].name), 32'(sof_cnt), 32'd1);
      if (vecs[v].slen > 0)
        check($sformatf("%s_stall_reads_le2", vecs[v].name), 32'(stall_reads <= 2), 32'd1);
      if (vecs[v].tpg)
        check($sformatf("%s_no_rd_en", vecs[v].name), 32'(issued), 32'd0);
      else
        check($sformatf("%s_first_addr", vecs[v].name), 32'(first_rd_addr), 32'd0);
      @(negedge clk); #1;
      check($sformatf("%s_done_pulse", vecs[v].name), 32'({bus.done, bus.busy}), 32'd0);
      $display("frame %s: done at +%0d, %0d pixels, %0d eol", vecs[v].name, done_edge - e0,
               xfer_cnt, eol_cnt);
      exp_q.delete();
    end

    // start during RUN and DRAIN is ignored; start in the done cycle launches a new frame
    reset_stats();
    rnd_ready = 1'b0;
    stall_at  = -1;
    start_frame(1'b0, e0);
    pulse_start_at(e0 + 50);
    pulse_start_at(e0 + N + 1);
    wait_done(4 * N, ok);
    check("restart_a_done_seen", 32'(ok), 32'd1);
    check("restart_a_done_cycle", 32'(done_edge - e0), 32'(N + 3));
    check("restart_a_queue", 32'(exp_q.size()), 32'd0);
    push_frame(1'b0);
    first_valid_edge = -1;
    bus.start = 1'b1;
    e1 = edge_cnt + 1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done(4 * N, ok);
    check("restart_b_done_seen", 32'(ok), 32'd1);
    check("restart_b_done_cycle", 32'(done_edge - e1), 32'(N + 3));
    check("restart_b_first_valid", 32'(first_valid_edge - e1), 32'd3);
    repeat (20) @(negedge clk);
    #1;
    check("restart_busy_after", 32'(bus.busy), 32'd0);
    check("restart_done_count", 32'(done_cnt), 32'd2);
    check("restart_xfers", 32'(xfer_cnt), 32'(2 * N));
    $display("restart: frame A done +%0d, frame B done +%0d, %0d pixels", e1 - 1 - e0,
             done_edge - e1, xfer_cnt);
    exp_q.delete();

    // reset mid-frame aborts without done, then a fresh frame starts from address 0
    reset_stats();
    start_frame(1'b0, e0);
    for (int i = 0; i < 4 * N && xfer_cnt < 100; i++) @(posedge clk);
    check("abort_reached_pixel", 32'(xfer_cnt >= 100), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_rd_en", 32'(bus.rd_en), 32'd0);
    check("abort_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("abort_pix", 32'({bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_eol}), 32'd0);
    check("abort_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    $display("abort: reset after %0d pixels, outputs cleared", xfer_cnt);
    exp_q.delete();
    reset_stats();
    start_frame(1'b0, e0);
    wait_done(4 * N, ok);
    check("after_abort_done_seen", 32'(ok), 32'd1);
    check("after_abort_first_addr", 32'(first_rd_addr), 32'd0);
    check("after_abort_done_cycle", 32'(done_edge - e0), 32'(N + 3));
    check("after_abort_xfers", 32'(xfer_cnt), 32'(N));
    $display("after abort: done at +%0d, %0d pixels", done_edge - e0, xfer_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time bound
  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: simulation exceeded time budget, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
